// File: rtl/result_printer.sv
// result_printer: converts a latched 16-bit calculator result to decimal by repeated
// subtraction, then streams '=', optional '-', the digits and an optional CR.
module result_printer #(
  parameter bit SIGNED  = 1'b1,
  parameter bit EMIT_EQ = 1'b1,
  parameter bit EMIT_CR = 1'b1
) (
  input  logic        clk_50m,
  input  logic        rst,
  input  logic        Finish,
  input  logic [15:0] Result,
  input  logic        char_ready,
  output logic [7:0]  asciiOut,
  output logic        char_valid,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [15:0]     rem_r;
  logic [4:0][3:0] digits_r;
  logic [2:0]      pos_r;
  logic            neg_r;
  logic [3:0]      idx_r;
  logic [3:0]      idx_s;

  logic [71:0]     list_s;
  logic [3:0]      len_s;
  logic            started_s;
  logic [15:0]     pow_s;
  logic            rem_ge_s;
  logic            accept_s;
  logic            last_s;
  logic            result_neg_s;

  logic [7:0]      ascii_s;
  logic            valid_s;
  logic            busy_s;
  logic            done_s;

  function automatic logic [15:0] pow10(input logic [2:0] p);
    case (p)
      3'd4:    pow10 = 16'd10000;
      3'd3:    pow10 = 16'd1000;
      3'd2:    pow10 = 16'd100;
      3'd1:    pow10 = 16'd10;
      3'd0:    pow10 = 16'd1;
      default: pow10 = 16'd1;
    endcase
  endfunction

  assign pow_s        = pow10(pos_r);
  assign rem_ge_s     = (rem_r >= pow_s);
  assign accept_s     = char_valid & char_ready;
  assign last_s       = (idx_r == (len_s - 4'd1));
  assign result_neg_s = SIGNED & Result[15];

  // Character list: each slot is written at the current length, and the length only
  // advances when the slot is wanted, so unwanted slots are overwritten by the next one.
  always_comb begin
    list_s    = 72'd0;
    len_s     = 4'd0;
    started_s = 1'b0;
    list_s[{len_s, 3'b000} +: 8] = 8'h3D;
    len_s = len_s + {3'b000, EMIT_EQ};
    list_s[{len_s, 3'b000} +: 8] = 8'h2D;
    len_s = len_s + {3'b000, neg_r};
    for (int i = 4; i >= 0; i--) begin
      started_s = started_s | (digits_r[i] != 4'd0) | (i == 0);
      list_s[{len_s, 3'b000} +: 8] = 8'h30 + {4'd0, digits_r[i]};
      len_s = len_s + {3'b000, started_s};
    end
    list_s[{len_s, 3'b000} +: 8] = 8'h0D;
    len_s = len_s + {3'b000, EMIT_CR};
  end

  // Next-state and next character index.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    case (state_r)
      IDLE: begin
        idx_s = 4'd0;
        if (Finish) state_s = CONV;
        else        state_s = IDLE;
      end
      CONV: begin
        idx_s = 4'd0;
        if (pos_r == 3'd0 && !rem_ge_s) state_s = EMIT;
        else                            state_s = CONV;
      end
      EMIT: begin
        if (accept_s && last_s) begin
          state_s = IDLE;
          idx_s   = 4'd0;
        end else if (accept_s) begin
          state_s = EMIT;
          idx_s   = idx_r + 4'd1;
        end else begin
          state_s = EMIT;
          idx_s   = idx_r;
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = 4'd0;
      end
    endcase
  end

  // Next output values, registered below so every output comes straight from a flop.
  always_comb begin
    ascii_s = 8'd0;
    valid_s = 1'b0;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    case (state_s)
      CONV: begin
        busy_s = 1'b1;
      end
      EMIT: begin
        busy_s  = 1'b1;
        valid_s = 1'b1;
        ascii_s = list_s[{idx_s, 3'b000} +: 8];
      end
      IDLE: begin
        done_s = (state_r == EMIT);
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
  end

  // State register and conversion datapath.
  always_ff @(posedge clk_50m) begin
    if (!rst) begin
      state_r  <= IDLE;
      rem_r    <= 16'd0;
      digits_r <= 20'd0;
      pos_r    <= 3'd0;
      neg_r    <= 1'b0;
      idx_r    <= 4'd0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      case (state_r)
        IDLE: begin
          if (Finish) begin
            neg_r    <= result_neg_s;
            rem_r    <= result_neg_s ? (16'd0 - Result) : Result;
            digits_r <= 20'd0;
            pos_r    <= 3'd4;
          end
        end
        CONV: begin
          if (rem_ge_s) begin
            rem_r           <= rem_r - pow_s;
            digits_r[pos_r] <= digits_r[pos_r] + 4'd1;
          end else if (pos_r != 3'd0) begin
            pos_r <= pos_r - 3'd1;
          end
        end
        default: begin
          rem_r <= rem_r;
        end
      endcase
    end
  end

  // Output registers.
  always_ff @(posedge clk_50m) begin
    if (!rst) begin
      asciiOut   <= 8'd0;
      char_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      asciiOut   <= ascii_s;
      char_valid <= valid_s;
      busy       <= busy_s;
      done       <= done_s;
    end
  end

endmodule
